booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
Parametrised, iterative radix-4 (modified Booth) multiplier that retires one Booth digit per clock. It supports signed and unsigned operands selected per operation. It uses valid/ready handshakes on both the operand and the result side, so it can sit directly on a streaming datapath. It is the next-generation multiplier for the cell-based arithmetic blocks, replacing fixed-width start/strobe multipliers.

Parameters:
WIDTH, 12, operand width in bits; must be even and >= 4. Product width is 2*WIDTH.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands; high only in IDLE
multiplicand  in  WIDTH  operand A
multiplier  in  WIDTH  operand B
signed_mode  in  1  1 = both operands two's complement; 0 = both unsigned; sampled with operands
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accepts result
result  out  2*WIDTH  product; registered
acc_clr  in  1  present only with BOOTH_ACC_EN; sampled with operands

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, result=0, digit counter=0, operand registers=0. in_ready=1 once reset is released. Reset mid-operation aborts the operation; no out_valid is produced.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On the edge where in_valid & in_ready:
  - capture multiplicand, multiplier and signed_mode;
  - clear the accumulator to 0 (see optional feature);
  - set the digit counter k to 0;
  - go to CALC.
- CALC: in_ready=0. Each cycle:
  - form digit k from {b[2k+1], b[2k], b[2k-1]}, with b[-1]=0;
  - add the partial product << 2k to the accumulator;
  - increment k.
  - Leave for DONE on the cycle that processes the last digit.
- Digit count NDIG: WIDTH/2 when signed_mode=1. WIDTH/2+1 when signed_mode=0; the multiplier is zero-extended by 2 bits so the top digit is non-negative.
- Booth recoding:
  - 000/111 -> 0
  - 001/010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101/110 -> -A
  - Negation is two's complement (invert + 1).
- Extension of A: sign-extended to 2*WIDTH when signed, zero-extended when unsigned.
- All accumulation is modulo 2^(2*WIDTH). The final product is exact for both modes.
- result is written from the accumulator on entry to DONE, and out_valid=1 in the same cycle.
- Latency: out_valid rises NDIG clock edges after the accepting edge. For WIDTH=12 that is 6 edges signed, 7 edges unsigned.
- DONE: out_valid=1 and result stable. On out_valid & out_ready, go to IDLE and drop out_valid next cycle; in_ready=1 from that cycle. result keeps its value until the next DONE entry.
- Throughput: one operation per NDIG+2 cycles when out_ready is held high.
- Operand input changes during CALC/DONE are ignored.
- in_valid while in_ready=0 is not accepted; the upstream must hold its operands.

Optional Feature:
BOOTH_ACC_EN
- Defined: adds the acc_clr port and gives multiply-accumulate behaviour. On accept, the accumulator is loaded with 0 if acc_clr=1, otherwise with the current result register value. result = previous result + A*B, wrapping modulo 2^(2*WIDTH). Mode mixing is allowed; the sum is plain two's-complement/modulo addition.
- Undefined: there is no acc_clr port, and the accumulator always clears to 0 on accept.

Test Plan:
- WIDTH=12, signed, A=-2048 (0x800), B=-2048 -> out_valid 6 edges after accept, result=0x400000.
- Unsigned, A=4095, B=4095 -> out_valid 7 edges after accept, result=0xFFE001. The same operands in signed mode give result=0x000001.
- Signed, A=2047, B=-2048 -> result=0xC00800. Then A=0, B=-1 -> result=0x000000.
- Backpressure: after a result, hold out_ready=0 for 5 cycles and drive in_valid=1 with new operands -> out_valid and result stay stable, in_ready=0, no capture. Raise out_ready -> next cycle in_ready=1 and the new pair is accepted.
- Assert reset 3 cycles into CALC -> out_valid=0, result=0, in_ready=1 after release. The next operation 3*5 (signed) -> 0x00000F.
- BOOTH_ACC_EN: 3*4 with acc_clr=1 -> 0x00000C. Then 5*6 with acc_clr=0 -> 0x00002A. Then -1*42 with acc_clr=0 -> 0x000000.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional multiply-accumulate mode (acc_clr port) is enabled by defining BOOTH_ACC_EN.
module booth_mult_seq #(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
`ifdef BOOTH_ACC_EN
    ,
    input  logic                 acc_clr
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int KW = $clog2(WIDTH / 2 + 2);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              signed_reg;
    logic [KW-1:0]     k_reg;
    logic [PW-1:0]     acc_reg;
    logic [PW-1:0]     result_reg;
    logic              out_valid_reg;

    logic [WIDTH+2:0]  b_ext;
    logic [2:0]        digit;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     pp_shift;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     acc_load;
    logic [KW-1:0]     last_k;
    logic              last_digit;
    logic              accept;

    // Two zero bits on top make the extra unsigned digit non-negative; b[-1]=0 at the bottom.
    assign b_ext = {2'b00, b_reg, 1'b0};
    assign digit = 3'(b_ext >> {k_reg, 1'b0});

    assign a_ext = signed_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg}
                              : {{WIDTH{1'b0}}, a_reg};

    always_comb begin
        pp = '0;
        case (digit)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = ~(a_ext << 1) + PW'(1);
            3'b101, 3'b110: pp = ~a_ext + PW'(1);
            default:        pp = '0;
        endcase
    end

    assign pp_shift   = pp << {k_reg, 1'b0};
    assign acc_next   = acc_reg + pp_shift;
    assign last_k     = signed_reg ? KW'(WIDTH / 2 - 1) : KW'(WIDTH / 2);
    assign last_digit = (k_reg == last_k);
    assign accept     = in_valid && (state_reg == IDLE);

`ifdef BOOTH_ACC_EN
    assign acc_load = acc_clr ? '0 : result_reg;
`else
    assign acc_load = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            signed_reg    <= 1'b0;
            k_reg         <= '0;
            acc_reg       <= '0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= multiplicand;
                        b_reg      <= multiplier;
                        signed_reg <= signed_mode;
                        acc_reg    <= acc_load;
                        k_reg      <= '0;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    k_reg   <= k_reg + KW'(1);
                    if (last_digit) begin
                        result_reg    <= acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomised and directed checks of booth_mult_seq against an arithmetic reference model.
module tb_booth_mult_seq;

    localparam int W  = 12;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          signed_mode = 1'b0;
    logic          out_ready = 1'b0;
    logic          acc_clr = 1'b1;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] result;

    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] model_acc = '0;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result)
`ifdef BOOTH_ACC_EN
        ,
        .acc_clr      (acc_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        logic [PW-1:0] ea, eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    function automatic void model_update(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic clr);
`ifdef BOOTH_ACC_EN
        if (clr) model_acc = '0;
`else
        model_acc = '0;
`endif
        model_acc = model_acc + ref_mul(a, b, s);
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic clr);
        @(negedge clk);
        check_val("in_ready_idle", in_ready, 1'b1);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = s;
        acc_clr      = clr;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_update(a, b, s, clr);
        check_val("in_ready_busy", in_ready, 1'b0);
    endtask

    task automatic wait_result(input logic s, input string tag);
        int n;
        int ndig;
        n    = 0;
        ndig = s ? W / 2 : W / 2 + 1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 40);
        check_val({tag, "_latency"}, n, ndig);
        check_val({tag, "_result"}, result, model_acc);
        $display("op %s signed=%0d latency=%0d result=0x%06h expected=0x%06h",
                 tag, s, n, result, model_acc);
    endtask

    task automatic ack(input int hold);
        repeat (hold) begin
            @(negedge clk);
            check_val("hold_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("ack_valid_drop", out_valid, 1'b0);
        check_val("ack_in_ready", in_ready, 1'b1);
        check_val("ack_result_kept", result, model_acc);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic clr, input string tag);
        start_op(a, b, s, clr);
        wait_result(s, tag);
        ack(0);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_result", result, '0);
        check_val("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        run(12'h800, 12'h800, 1'b1, 1'b1, "smin_x_smin");
        check_val("tp_smin_smin", result, 24'h400000);
        run(12'hFFF, 12'hFFF, 1'b0, 1'b1, "umax_x_umax");
        check_val("tp_umax_umax", result, 24'hFFE001);
        run(12'hFFF, 12'hFFF, 1'b1, 1'b1, "m1_x_m1");
        check_val("tp_m1_m1", result, 24'h000001);
        run(12'h7FF, 12'h800, 1'b1, 1'b1, "smax_x_smin");
        check_val("tp_smax_smin", result, 24'hC00800);
        run(12'h000, 12'hFFF, 1'b1, 1'b1, "zero_x_m1");
        check_val("tp_zero", result, 24'h000000);

        // Backpressure: offered operands must not be taken while a result is pending.
        start_op(12'h123, 12'h456, 1'b0, 1'b1);
        wait_result(1'b0, "bp_first");
        @(negedge clk);
        multiplicand = 12'h055;
        multiplier   = 12'h0AA;
        signed_mode  = 1'b1;
        acc_clr      = 1'b1;
        in_valid     = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_val("bp_out_valid", out_valid, 1'b1);
            check_val("bp_result", result, model_acc);
            check_val("bp_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("bp_release_valid", out_valid, 1'b0);
        check_val("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_update(12'h055, 12'h0AA, 1'b1, 1'b1);
        check_val("bp_accepted", in_ready, 1'b0);
        wait_result(1'b1, "bp_second");
        ack(0);

        // Reset in the middle of a calculation aborts it.
        start_op(12'h0AB, 12'h0CD, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_val("abort_out_valid", out_valid, 1'b0);
        check_val("abort_result", result, '0);
        check_val("abort_in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        model_acc = '0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_val("abort_no_valid", seen, 0);
        run(12'd3, 12'd5, 1'b1, 1'b1, "after_reset");
        check_val("tp_3x5", result, 24'h00000F);

`ifdef BOOTH_ACC_EN
        run(12'd3, 12'd4, 1'b1, 1'b1, "mac_clr");
        check_val("tp_mac_c", result, 24'h00000C);
        run(12'd5, 12'd6, 1'b1, 1'b0, "mac_add");
        check_val("tp_mac_2a", result, 24'h00002A);
        run(12'hFFF, 12'd42, 1'b1, 1'b0, "mac_neg");
        check_val("tp_mac_zero", result, 24'h000000);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs, rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
`ifdef BOOTH_ACC_EN
            rc = 1'($urandom_range(0, 1));
`else
            rc = 1'b1;
`endif
            start_op(ra, rb, rs, rc);
            wait_result(rs, $sformatf("rand%0d", i));
            ack(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
